// File: rtl/tt_display_scan_if.sv
// Bus between the segment decoder side and the two-digit scan driver:
// segment snapshot source, scan controls, and multiplexed display outputs.
interface tt_display_scan_if;
  logic [13:0] segs_in;
  logic        en;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic [1:0]  dig;
  logic        frame_tick;

  modport master (
    output segs_in, en, brightness,
    input  seg, dig, frame_tick
  );

  modport slave (
    input  segs_in, en, brightness,
    output seg, dig, frame_tick
  );
endinterface

// File: rtl/tt_display_scan.sv
// Two-digit time-multiplexed seven-segment scan driver with dead-time
// blanking, 4-bit PWM brightness and a once-per-frame segment snapshot.
module tt_display_scan #(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  tt_display_scan_if.slave bus
);

  localparam int CNT_LEN = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_LEN);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [13:0]     snap_reg;
  logic [6:0]      seg_reg;
  logic [1:0]      dig_reg;
  logic            tick_reg;
  logic            wrap_reg;
  logic            slot_last;
  logic            gate;

  always_comb begin
    state_next = BLANK0;
    case (state_reg)
      BLANK0:  state_next = SHOW0;
      SHOW0:   state_next = BLANK1;
      BLANK1:  state_next = SHOW1;
      default: state_next = BLANK0;
    endcase
  end

  assign slot_last = (state_reg == SHOW0 || state_reg == SHOW1) ? (cnt_reg == SHOW_LAST)
                                                                : (cnt_reg == BLANK_LAST);
  assign gate      = (bus.brightness == 4'hF) || (cnt_reg[3:0] < bus.brightness);

  // wrap_reg remembers a completed SHOW1 so the tick lands on the first
  // blanked output cycle of the following frame rather than on the last lit one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BLANK0;
      cnt_reg   <= '0;
      snap_reg  <= '0;
      seg_reg   <= '0;
      dig_reg   <= '0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      if (!bus.en || (state_reg == BLANK0 && cnt_reg == '0))
        snap_reg <= bus.segs_in;

      seg_reg  <= '0;
      dig_reg  <= '0;
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;

      if (!bus.en) begin
        state_reg <= BLANK0;
        cnt_reg   <= '0;
      end else begin
        tick_reg <= wrap_reg;
        case (state_reg)
          SHOW0: begin
            dig_reg <= 2'b01;
            if (gate) seg_reg <= snap_reg[6:0];
          end
          SHOW1: begin
            dig_reg <= 2'b10;
            if (gate) seg_reg <= snap_reg[13:7];
          end
          default: ;
        endcase

        if (slot_last) begin
          cnt_reg   <= '0;
          state_reg <= state_next;
          wrap_reg  <= (state_reg == SHOW1);
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dig        = dig_reg;
  assign bus.frame_tick = tick_reg;

endmodule

// File: tb/tb_tt_display_scan.sv
// Directed bench for tt_display_scan: phase-table checks of the scan pattern
// plus hand sequences for snapshot, enable gating and async reset.
module tb_tt_display_scan;
  localparam int SD = 32;
  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_display_scan_if bus();

  tt_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int s = 0;

  typedef struct {
    int         len;
    logic [1:0] dig;
    int         digit;      // -1: blanked, 0/1: which snapshot digit is shown
    bit         tick_first;
  } phase_t;

  phase_t ph[9];
  logic [13:0] segs_a;
  logic [13:0] segs_b;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at sample %0d: got %h, expected %h", name, s, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    s++;
  endtask

  task automatic advance_to(input int n);
    while (s < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_seg", 16'(bus.seg), 16'(0));
    chk("reset_dig", 16'(bus.dig), 16'(0));
    chk("reset_tick", 16'(bus.frame_tick), 16'(0));
    rst = 1'b0;
    s = 0;
  endtask

  task automatic check_phases(input logic [3:0] bri, input logic [13:0] segs);
    logic [6:0] d;
    logic [6:0] exp_seg;
    bus.brightness = bri;
    bus.segs_in    = segs;
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < ph[p].len; i++) begin
        if (p != 0 || i != 0) tick();
        d       = (ph[p].digit == 1) ? segs[13:7] : segs[6:0];
        exp_seg = 7'b0;
        if (ph[p].digit >= 0 && (bri == 4'hF || (i % 16) < int'(bri)))
          exp_seg = d;
        chk("scan_dig", 16'(bus.dig), 16'(ph[p].dig));
        chk("scan_seg", 16'(bus.seg), 16'(exp_seg));
        chk("scan_tick", 16'(bus.frame_tick), 16'(ph[p].tick_first && i == 0));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("dig_never_11", 16'(bus.dig == 2'b11), 16'(0));
      if (bus.dig == 2'b00) chk("seg_dark_when_no_digit", 16'(bus.seg), 16'(0));
    end
  end

  initial begin
    segs_a = {7'b0110000, 7'b0000001};
    segs_b = {7'b1111001, 7'b0110011};
    bus.en         = 1'b1;
    bus.brightness = 4'hF;
    bus.segs_in    = segs_a;

    // Expected output phases from reset release; sample 0 is taken at release.
    ph[0] = '{BC + 1, 2'b00, -1, 1'b0};
    ph[1] = '{SD,     2'b01,  0, 1'b0};
    ph[2] = '{BC,     2'b00, -1, 1'b0};
    ph[3] = '{SD,     2'b10,  1, 1'b0};
    ph[4] = '{BC,     2'b00, -1, 1'b1};
    ph[5] = '{SD,     2'b01,  0, 1'b0};
    ph[6] = '{BC,     2'b00, -1, 1'b0};
    ph[7] = '{SD,     2'b10,  1, 1'b0};
    ph[8] = '{BC,     2'b00, -1, 1'b1};

    do_reset();
    check_phases(4'hF, segs_a);
    do_reset();
    check_phases(4'h4, segs_a);
    do_reset();
    check_phases(4'h0, segs_a);

    // Snapshot integrity: change the bus mid-SHOW0.
    bus.brightness = 4'hF;
    bus.segs_in    = segs_a;
    do_reset();
    advance_to(20);
    bus.segs_in = segs_b;
    advance_to(25);
    chk("snap_old_d0", 16'(bus.seg), 16'(segs_a[6:0]));
    advance_to(50);
    chk("snap_old_d1", 16'(bus.seg), 16'(segs_a[13:7]));
    advance_to(87);
    chk("snap_new_d0", 16'(bus.seg), 16'(segs_b[6:0]));
    advance_to(118);
    chk("snap_new_d1", 16'(bus.seg), 16'(segs_b[13:7]));

    // Enable gating mid-SHOW1.
    bus.segs_in = segs_a;
    do_reset();
    advance_to(50);
    chk("en_pre_dig", 16'(bus.dig), 16'(2'b10));
    bus.en = 1'b0;
    repeat (10) begin
      tick();
      chk("en_off_dig", 16'(bus.dig), 16'(0));
      chk("en_off_seg", 16'(bus.seg), 16'(0));
      chk("en_off_tick", 16'(bus.frame_tick), 16'(0));
    end
    bus.en = 1'b1;
    s = 0;
    check_phases(4'hF, segs_a);

    // Asynchronous reset between edges while in SHOW0.
    do_reset();
    advance_to(20);
    chk("async_pre_dig", 16'(bus.dig), 16'(2'b01));
    #1 rst = 1'b1;
    #1;
    chk("async_seg", 16'(bus.seg), 16'(0));
    chk("async_dig", 16'(bus.dig), 16'(0));
    chk("async_tick", 16'(bus.frame_tick), 16'(0));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    s = 0;
    check_phases(4'hF, segs_a);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
